// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM state type, spi_mode encodings, idle transmit byte
// and the bit-shift helpers used by the slave serial engine.
package spi_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } spi_state_e;

    localparam logic [1:0] SPI_RUN  = 2'b00;
    localparam logic [1:0] SPI_WAIT = 2'b01;

    localparam logic [7:0] TX_IDLE_BYTE = 8'hFF;

    // Receive shift: the new bit enters at the end that fills last in wire order.
    function automatic logic [7:0] shift_in(input logic [7:0] cur,
                                            input logic       bit_in,
                                            input logic       lsb_first);
        shift_in = lsb_first ? {bit_in, cur[7:1]} : {cur[6:0], bit_in};
    endfunction

    // Transmit shift: vacated positions fill with 1 so an exhausted shifter idles high.
    function automatic logic [7:0] shift_out(input logic [7:0] cur,
                                             input logic       lsb_first);
        shift_out = lsb_first ? {1'b1, cur[7:1]} : {cur[6:0], 1'b1};
    endfunction

endpackage

// File: rtl/spi_slave_shifter_if.sv
// Register-file side of the SPI slave engine: transmit holding write,
// received byte handshake and status flags.
interface spi_slave_shifter_if;

    logic [7:0] tx_data_i;
    logic       tx_load_i;
    logic       tx_empty_o;
    logic [7:0] rx_data_o;
    logic       rx_rdy_o;
    logic       rx_ack_i;
    logic       ovr_o;
    logic       tip_o;

    modport slave (
        input  tx_data_i, tx_load_i, rx_ack_i,
        output tx_empty_o, rx_data_o, rx_rdy_o, ovr_o, tip_o
    );

    modport master (
        output tx_data_i, tx_load_i, rx_ack_i,
        input  tx_empty_o, rx_data_o, rx_rdy_o, ovr_o, tip_o
    );

endinterface

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser for an asynchronous pin followed by an edge register
// producing one-PCLK rise/fall pulses three PCLK after the pin changes.
module spi_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic PCLK,
    input  logic PRESET_n,
    input  logic pin,
    output logic rise_p2,
    output logic fall_p2
);

    logic sync_p0;
    logic sync_p1;
    logic prev_p2;

    // Reset to the pin's idle level so leaving reset never fabricates an edge.
    always_ff @(posedge PCLK or negedge PRESET_n) begin
        if (!PRESET_n) begin
            sync_p0 <= RST_VAL;
            sync_p1 <= RST_VAL;
            prev_p2 <= RST_VAL;
            rise_p2 <= 1'b0;
            fall_p2 <= 1'b0;
        end else begin
            sync_p0 <= pin;
            sync_p1 <= sync_p0;
            prev_p2 <= sync_p1;
            rise_p2 <= sync_p1 & ~prev_p2;
            fall_p2 <= ~sync_p1 & prev_p2;
        end
    end

endmodule

// File: rtl/spi_slave_shifter.sv
// SPI slave serial engine: pin synchronisation, CPOL/CPHA edge decode, rx/tx
// byte shifters and the register-file handshake. Optional: SPI_SLV_OVERRUN_EN.
module spi_slave_shifter
    import spi_pkg::*;
(
    input  logic       PCLK,
    input  logic       PRESET_n,
    input  logic       mstr_i,
    input  logic       spe_i,
    input  logic       spiswai_i,
    input  logic [1:0] spi_mode_i,
    input  logic       cpol_i,
    input  logic       cpha_i,
    input  logic       lsbfe_i,
    input  logic       ss_i,
    input  logic       sclk_i,
    input  logic       mosi_i,
    output logic       miso_o,
    output logic       miso_oe_o,
    spi_slave_shifter_if.slave bus
);

    localparam logic [0:0] IDLE = ST_IDLE;
    localparam logic [0:0] XFER = ST_XFER;

    logic [0:0] state;
    logic [2:0] bit_cnt;
    logic [7:0] tx_shift;
    logic [7:0] rx_shift;
    logic [7:0] hold;
    logic       tx_empty;
    logic [7:0] rx_data;
    logic       rx_rdy;
    logic       ovr;

    logic       sclk_rise_p2, sclk_fall_p2;
    logic       ss_rise_p2, ss_fall_p2;
    logic       mosi_p0, mosi_p1;

    spi_sync_edge #(.RST_VAL(1'b0)) u_sclk_sync (
        .PCLK     (PCLK),
        .PRESET_n (PRESET_n),
        .pin      (sclk_i),
        .rise_p2  (sclk_rise_p2),
        .fall_p2  (sclk_fall_p2)
    );

    spi_sync_edge #(.RST_VAL(1'b1)) u_ss_sync (
        .PCLK     (PCLK),
        .PRESET_n (PRESET_n),
        .pin      (ss_i),
        .rise_p2  (ss_rise_p2),
        .fall_p2  (ss_fall_p2)
    );

    // MOSI needs no edge detect; two flops keep it level with the sclk pulses.
    always_ff @(posedge PCLK or negedge PRESET_n) begin
        if (!PRESET_n) begin
            mosi_p0 <= 1'b0;
            mosi_p1 <= 1'b0;
        end else begin
            mosi_p0 <= mosi_i;
            mosi_p1 <= mosi_p0;
        end
    end

    logic       enabled;
    logic       sample_evt, shift_evt;
    logic       start, stop;
    logic       sample_go, shift_go;
    logic       done;
    logic       tx_reload;
    logic [7:0] rx_next;

    assign enabled = !mstr_i && spe_i &&
                     ((spi_mode_i == SPI_RUN) || ((spi_mode_i == SPI_WAIT) && !spiswai_i));

    // CPOL^CPHA selects which physical sclk edge is the sampling one.
    assign sample_evt = (cpol_i ^ cpha_i) ? sclk_fall_p2 : sclk_rise_p2;
    assign shift_evt  = (cpol_i ^ cpha_i) ? sclk_rise_p2 : sclk_fall_p2;

    assign start     = (state == IDLE) && enabled && ss_fall_p2;
    assign stop      = (state == XFER) && (ss_rise_p2 || !enabled);
    assign sample_go = (state == XFER) && !stop && sample_evt;
    assign shift_go  = (state == XFER) && !stop && shift_evt && (bit_cnt != 3'd0);
    assign done      = sample_go && (bit_cnt == 3'd7);
    assign tx_reload = start || done;
    assign rx_next   = shift_in(rx_shift, mosi_p1, lsbfe_i);

    always_ff @(posedge PCLK or negedge PRESET_n) begin
        if (!PRESET_n) begin
            state    <= IDLE;
            bit_cnt  <= 3'd0;
            tx_shift <= TX_IDLE_BYTE;
            rx_shift <= 8'h00;
            hold     <= TX_IDLE_BYTE;
            tx_empty <= 1'b1;
        end else begin
            case (state)
                IDLE:    if (start) state <= XFER;
                XFER:    if (stop)  state <= IDLE;
                default: state <= IDLE;
            endcase

            if (start || stop)
                bit_cnt <= 3'd0;
            else if (sample_go)
                bit_cnt <= bit_cnt + 3'd1;

            if (sample_go)
                rx_shift <= rx_next;

            // A reload takes the holding content as it stood before any same-cycle write.
            if (tx_reload)
                tx_shift <= tx_empty ? TX_IDLE_BYTE : hold;
            else if (shift_go)
                tx_shift <= shift_out(tx_shift, lsbfe_i);

            if (bus.tx_load_i)
                hold <= bus.tx_data_i;

            if (bus.tx_load_i)
                tx_empty <= 1'b0;
            else if (tx_reload)
                tx_empty <= 1'b1;
        end
    end

`ifdef SPI_SLV_OVERRUN_EN
    // An unacknowledged byte is preserved; the newer one is dropped and flagged.
    always_ff @(posedge PCLK or negedge PRESET_n) begin
        if (!PRESET_n) begin
            rx_data <= 8'h00;
            rx_rdy  <= 1'b0;
            ovr     <= 1'b0;
        end else if (done) begin
            if (rx_rdy && !bus.rx_ack_i) begin
                ovr <= 1'b1;
            end else begin
                rx_data <= rx_next;
                rx_rdy  <= 1'b1;
                if (bus.rx_ack_i)
                    ovr <= 1'b0;
            end
        end else if (bus.rx_ack_i) begin
            rx_rdy <= 1'b0;
            ovr    <= 1'b0;
        end
    end
`else
    always_ff @(posedge PCLK or negedge PRESET_n) begin
        if (!PRESET_n) begin
            rx_data <= 8'h00;
            rx_rdy  <= 1'b0;
        end else if (done) begin
            rx_data <= rx_next;
            rx_rdy  <= 1'b1;
        end else if (bus.rx_ack_i) begin
            rx_rdy <= 1'b0;
        end
    end

    assign ovr = 1'b0;
`endif

    assign miso_o         = lsbfe_i ? tx_shift[0] : tx_shift[7];
    assign miso_oe_o      = (state == XFER);
    assign bus.tip_o      = (state == XFER);
    assign bus.tx_empty_o = tx_empty;
    assign bus.rx_data_o  = rx_data;
    assign bus.rx_rdy_o   = rx_rdy;
    assign bus.ovr_o      = ovr;

endmodule

// File: tb/tb_spi_slave_shifter.sv
// Directed bench for spi_slave_shifter: a bit-banged SPI master drives the pins
// and each scenario task checks the slave against hand-computed values.
module tb_spi_slave_shifter;

    logic       PCLK = 1'b0;
    logic       PRESET_n = 1'b0;
    logic       mstr_i = 1'b0;
    logic       spe_i = 1'b1;
    logic       spiswai_i = 1'b0;
    logic [1:0] spi_mode_i = 2'b00;
    logic       cpol_i = 1'b0;
    logic       cpha_i = 1'b0;
    logic       lsbfe_i = 1'b0;
    logic       ss_i = 1'b1;
    logic       sclk_i = 1'b0;
    logic       mosi_i = 1'b0;
    logic       miso_o;
    logic       miso_oe_o;

    int n_checks = 0;
    int n_fail = 0;

    always #5 PCLK = ~PCLK;

    spi_slave_shifter_if bus ();

    spi_slave_shifter dut (
        .PCLK       (PCLK),
        .PRESET_n   (PRESET_n),
        .mstr_i     (mstr_i),
        .spe_i      (spe_i),
        .spiswai_i  (spiswai_i),
        .spi_mode_i (spi_mode_i),
        .cpol_i     (cpol_i),
        .cpha_i     (cpha_i),
        .lsbfe_i    (lsbfe_i),
        .ss_i       (ss_i),
        .sclk_i     (sclk_i),
        .mosi_i     (mosi_i),
        .miso_o     (miso_o),
        .miso_oe_o  (miso_oe_o),
        .bus        (bus)
    );

    task automatic tick(input int n);
        repeat (n) @(negedge PCLK);
    endtask

    task automatic half();
        tick(6);
    endtask

    task automatic load_tx(input logic [7:0] d);
        bus.tx_data_i = d;
        bus.tx_load_i = 1'b1;
        tick(1);
        bus.tx_load_i = 1'b0;
    endtask

    task automatic ack_rx();
        bus.rx_ack_i = 1'b1;
        tick(1);
        bus.rx_ack_i = 1'b0;
    endtask

    task automatic ss_start();
        ss_i = 1'b0;
        tick(8);
    endtask

    task automatic ss_end();
        tick(8);
        ss_i = 1'b1;
        tick(8);
    endtask

    // Master side: seq collects MISO in wire order, first bit ending up in bit 7.
    task automatic spi_bits(input logic [7:0] d, input int nbits, output logic [7:0] seq);
        logic b;
        seq = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            b = lsbfe_i ? d[i] : d[7-i];
            if (!cpha_i) begin
                mosi_i = b;
                half();
                sclk_i = ~cpol_i;
                seq = {seq[6:0], miso_o};
                half();
                sclk_i = cpol_i;
            end else begin
                half();
                sclk_i = ~cpol_i;
                mosi_i = b;
                half();
                sclk_i = cpol_i;
                seq = {seq[6:0], miso_o};
            end
        end
    endtask

    task automatic set_mode(input logic cpol, input logic cpha, input logic lsbfe);
        cpol_i  = cpol;
        cpha_i  = cpha;
        lsbfe_i = lsbfe;
        sclk_i  = cpol;
        tick(6);
    endtask

    task automatic test_reset();
        n_checks++; if (miso_o !== 1'b1) begin n_fail++; $display("FAIL reset_miso: got %b want 1", miso_o); end
        n_checks++; if (miso_oe_o !== 1'b0) begin n_fail++; $display("FAIL reset_miso_oe: got %b want 0", miso_oe_o); end
        n_checks++; if (bus.tx_empty_o !== 1'b1) begin n_fail++; $display("FAIL reset_tx_empty: got %b want 1", bus.tx_empty_o); end
        n_checks++; if (bus.rx_data_o !== 8'h00) begin n_fail++; $display("FAIL reset_rx_data: got %h want 00", bus.rx_data_o); end
        n_checks++; if (bus.rx_rdy_o !== 1'b0) begin n_fail++; $display("FAIL reset_rx_rdy: got %b want 0", bus.rx_rdy_o); end
        n_checks++; if (bus.ovr_o !== 1'b0) begin n_fail++; $display("FAIL reset_ovr: got %b want 0", bus.ovr_o); end
        n_checks++; if (bus.tip_o !== 1'b0) begin n_fail++; $display("FAIL reset_tip: got %b want 0", bus.tip_o); end
    endtask

    task automatic test_disabled();
        mstr_i = 1'b1;
        ss_i = 1'b0;
        tick(8);
        n_checks++; if (bus.tip_o !== 1'b0) begin n_fail++; $display("FAIL dis_mstr_tip: got %b want 0", bus.tip_o); end
        n_checks++; if (miso_oe_o !== 1'b0) begin n_fail++; $display("FAIL dis_mstr_oe: got %b want 0", miso_oe_o); end
        ss_i = 1'b1;
        tick(8);
        mstr_i = 1'b0;
        spi_mode_i = 2'b01;
        spiswai_i = 1'b1;
        ss_i = 1'b0;
        tick(8);
        n_checks++; if (bus.tip_o !== 1'b0) begin n_fail++; $display("FAIL dis_wait_tip: got %b want 0", bus.tip_o); end
        ss_i = 1'b1;
        tick(8);
        spiswai_i = 1'b0;
        spi_mode_i = 2'b00;
        tick(4);
    endtask

    task automatic test_mode0();
        logic [7:0] seq;
        set_mode(1'b0, 1'b0, 1'b0);
        load_tx(8'h3C);
        n_checks++; if (bus.tx_empty_o !== 1'b0) begin n_fail++; $display("FAIL m0_tx_empty_load: got %b want 0", bus.tx_empty_o); end
        ss_i = 1'b0;
        tick(3);
        n_checks++; if (miso_o !== 1'b1) begin n_fail++; $display("FAIL m0_miso_early: got %b want 1", miso_o); end
        tick(1);
        n_checks++; if (miso_o !== 1'b0) begin n_fail++; $display("FAIL m0_miso_first: got %b want 0", miso_o); end
        n_checks++; if (bus.tip_o !== 1'b1) begin n_fail++; $display("FAIL m0_tip: got %b want 1", bus.tip_o); end
        n_checks++; if (miso_oe_o !== 1'b1) begin n_fail++; $display("FAIL m0_oe: got %b want 1", miso_oe_o); end
        n_checks++; if (bus.tx_empty_o !== 1'b1) begin n_fail++; $display("FAIL m0_tx_empty_start: got %b want 1", bus.tx_empty_o); end
        tick(4);
        spi_bits(8'hA5, 8, seq);
        n_checks++; if (seq !== 8'b0011_1100) begin n_fail++; $display("FAIL m0_miso_seq: got %b want 00111100", seq); end
        n_checks++; if (bus.rx_data_o !== 8'hA5) begin n_fail++; $display("FAIL m0_rx_data: got %h want a5", bus.rx_data_o); end
        n_checks++; if (bus.rx_rdy_o !== 1'b1) begin n_fail++; $display("FAIL m0_rx_rdy: got %b want 1", bus.rx_rdy_o); end
        tick(6);
        n_checks++; if (bus.rx_rdy_o !== 1'b1) begin n_fail++; $display("FAIL m0_rx_rdy_level: got %b want 1", bus.rx_rdy_o); end
        ack_rx();
        n_checks++; if (bus.rx_rdy_o !== 1'b0) begin n_fail++; $display("FAIL m0_rx_ack: got %b want 0", bus.rx_rdy_o); end
        ss_end();
        n_checks++; if (bus.tip_o !== 1'b0) begin n_fail++; $display("FAIL m0_tip_end: got %b want 0", bus.tip_o); end
        n_checks++; if (miso_oe_o !== 1'b0) begin n_fail++; $display("FAIL m0_oe_end: got %b want 0", miso_oe_o); end
    endtask

    task automatic test_mode3();
        logic [7:0] seq;
        set_mode(1'b1, 1'b1, 1'b1);
        load_tx(8'h81);
        ss_start();
        spi_bits(8'h0F, 8, seq);
        tick(3);
        n_checks++; if (bus.rx_rdy_o !== 1'b0) begin n_fail++; $display("FAIL m3_rx_rdy_early: got %b want 0", bus.rx_rdy_o); end
        tick(1);
        n_checks++; if (bus.rx_rdy_o !== 1'b1) begin n_fail++; $display("FAIL m3_rx_rdy_lat4: got %b want 1", bus.rx_rdy_o); end
        n_checks++; if (seq !== 8'b1000_0001) begin n_fail++; $display("FAIL m3_miso_seq: got %b want 10000001", seq); end
        n_checks++; if (bus.rx_data_o !== 8'h0F) begin n_fail++; $display("FAIL m3_rx_data: got %h want 0f", bus.rx_data_o); end
        ack_rx();
        ss_end();
    endtask

    task automatic test_back_to_back();
        logic [7:0] seq;
        set_mode(1'b0, 1'b0, 1'b0);
        load_tx(8'h5A);
        ss_start();
        spi_bits(8'h12, 8, seq);
        n_checks++; if (seq !== 8'h5A) begin n_fail++; $display("FAIL b2b_seq1: got %h want 5a", seq); end
        n_checks++; if (bus.rx_data_o !== 8'h12) begin n_fail++; $display("FAIL b2b_rx1: got %h want 12", bus.rx_data_o); end
        n_checks++; if (bus.tx_empty_o !== 1'b1) begin n_fail++; $display("FAIL b2b_tx_empty: got %b want 1", bus.tx_empty_o); end
        ack_rx();
        spi_bits(8'h34, 8, seq);
        n_checks++; if (seq !== 8'hFF) begin n_fail++; $display("FAIL b2b_seq2: got %h want ff", seq); end
        n_checks++; if (bus.rx_data_o !== 8'h34) begin n_fail++; $display("FAIL b2b_rx2: got %h want 34", bus.rx_data_o); end
        n_checks++; if (bus.rx_rdy_o !== 1'b1) begin n_fail++; $display("FAIL b2b_rdy2: got %b want 1", bus.rx_rdy_o); end
        ack_rx();
        ss_end();
    endtask

    task automatic test_abort();
        logic [7:0] seq;
        ss_start();
        spi_bits(8'hF0, 5, seq);
        ss_end();
        n_checks++; if (bus.rx_rdy_o !== 1'b0) begin n_fail++; $display("FAIL abort_rdy: got %b want 0", bus.rx_rdy_o); end
        n_checks++; if (bus.rx_data_o !== 8'h34) begin n_fail++; $display("FAIL abort_rx_kept: got %h want 34", bus.rx_data_o); end
        n_checks++; if (bus.tip_o !== 1'b0) begin n_fail++; $display("FAIL abort_tip: got %b want 0", bus.tip_o); end
        ss_start();
        spi_bits(8'h55, 8, seq);
        tick(2);
        n_checks++; if (bus.rx_data_o !== 8'h55) begin n_fail++; $display("FAIL abort_rx_next: got %h want 55", bus.rx_data_o); end
        n_checks++; if (bus.rx_rdy_o !== 1'b1) begin n_fail++; $display("FAIL abort_rdy_next: got %b want 1", bus.rx_rdy_o); end
        ack_rx();
        ss_end();
    endtask

    task automatic test_overrun();
        logic [7:0] seq;
        ss_start();
        spi_bits(8'h11, 8, seq);
        spi_bits(8'h22, 8, seq);
        tick(2);
        n_checks++; if (bus.rx_rdy_o !== 1'b1) begin n_fail++; $display("FAIL ovr_rdy: got %b want 1", bus.rx_rdy_o); end
`ifdef SPI_SLV_OVERRUN_EN
        n_checks++; if (bus.ovr_o !== 1'b1) begin n_fail++; $display("FAIL ovr_flag: got %b want 1", bus.ovr_o); end
        n_checks++; if (bus.rx_data_o !== 8'h11) begin n_fail++; $display("FAIL ovr_rx_data: got %h want 11", bus.rx_data_o); end
`else
        n_checks++; if (bus.ovr_o !== 1'b0) begin n_fail++; $display("FAIL ovr_flag: got %b want 0", bus.ovr_o); end
        n_checks++; if (bus.rx_data_o !== 8'h22) begin n_fail++; $display("FAIL ovr_rx_data: got %h want 22", bus.rx_data_o); end
`endif
        ack_rx();
        n_checks++; if (bus.rx_rdy_o !== 1'b0) begin n_fail++; $display("FAIL ovr_ack_rdy: got %b want 0", bus.rx_rdy_o); end
        n_checks++; if (bus.ovr_o !== 1'b0) begin n_fail++; $display("FAIL ovr_ack_flag: got %b want 0", bus.ovr_o); end
        ss_end();
    endtask

    task automatic test_reset_mid();
        logic [7:0] seq;
        load_tx(8'h3C);
        ss_start();
        spi_bits(8'h00, 4, seq);
        PRESET_n = 1'b0;
        #1;
        n_checks++; if (bus.tip_o !== 1'b0) begin n_fail++; $display("FAIL rmid_tip: got %b want 0", bus.tip_o); end
        n_checks++; if (miso_oe_o !== 1'b0) begin n_fail++; $display("FAIL rmid_oe: got %b want 0", miso_oe_o); end
        n_checks++; if (miso_o !== 1'b1) begin n_fail++; $display("FAIL rmid_miso: got %b want 1", miso_o); end
        n_checks++; if (bus.tx_empty_o !== 1'b1) begin n_fail++; $display("FAIL rmid_tx_empty: got %b want 1", bus.tx_empty_o); end
        n_checks++; if (bus.rx_data_o !== 8'h00) begin n_fail++; $display("FAIL rmid_rx_data: got %h want 00", bus.rx_data_o); end
        n_checks++; if (bus.rx_rdy_o !== 1'b0) begin n_fail++; $display("FAIL rmid_rx_rdy: got %b want 0", bus.rx_rdy_o); end
        ss_i = 1'b1;
        sclk_i = cpol_i;
        tick(2);
        PRESET_n = 1'b1;
        tick(6);
        ss_start();
        spi_bits(8'h99, 8, seq);
        tick(2);
        n_checks++; if (seq !== 8'hFF) begin n_fail++; $display("FAIL rmid_seq: got %h want ff", seq); end
        n_checks++; if (bus.rx_data_o !== 8'h99) begin n_fail++; $display("FAIL rmid_rx_next: got %h want 99", bus.rx_data_o); end
        n_checks++; if (bus.rx_rdy_o !== 1'b1) begin n_fail++; $display("FAIL rmid_rdy_next: got %b want 1", bus.rx_rdy_o); end
        ack_rx();
        ss_end();
    endtask

    initial begin
        bus.tx_data_i = 8'h00;
        bus.tx_load_i = 1'b0;
        bus.rx_ack_i  = 1'b0;
        tick(3);
        test_reset();
        PRESET_n = 1'b1;
        tick(4);
        test_reset();
        test_disabled();
        test_mode0();
        test_mode3();
        test_back_to_back();
        test_abort();
        test_overrun();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
